pipelined_rca_adder: RTL and testbench
======================================

# pipelined_rca_adder

Parametrised, pipelined successor to the team's 4-bit ripple-carry adder. It adds or subtracts two WIDTH-bit operands by splitting the carry chain into STAGE_W-bit ripple slices, with one register stage per slice. A valid/ready handshake with full back-pressure lets it sit directly in the datapath between producer and consumer blocks. It also adds subtract mode, carry-out and signed-overflow flags, none of which the 4-bit adder provides.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of STAGE_W.
- STAGE_W, 8, bits per ripple slice and per pipeline stage; STAGES = WIDTH/STAGE_W (≥1).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block accepts input this cycle.
- a  in  WIDTH  operand A (unsigned or two's complement).
- b  in  WIDTH  operand B.
- cin  in  1  carry-in, used only when sub=0.
- sub  in  1  0: a+b+cin; 1: a−b (a+~b+1, cin ignored).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB (for sub: 1 = no borrow).
- overflow  out  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
- Global advance: adv = !out_valid || out_ready; in_ready = adv (combinational, no dependency on in_valid).
- When adv=1, every stage register loads from its predecessor; stage 0 loads the input (valid bit = in_valid). When adv=0, all stages hold.
- Stage k (0..STAGES−1) ripples slice k (bits k·STAGE_W .. (k+1)·STAGE_W−1) using the carry registered by stage k−1; stage 0 uses sub ? 1 : cin.
- Operand skew: slices not yet consumed travel forward with the transaction; B is inverted at input when sub=1, so later stages need no mode bit.
- Result de-skew: completed lower slices travel forward so that sum is fully aligned at the output.
- Last stage also registers the MSB-carry-in for overflow.
- Bubbles (valid=0) advance like data; their data contents are don't-care, but the valid bits must be exact.
- STAGES=1 degenerates to a single registered WIDTH-bit ripple adder with the same handshake.

## Timing
- Latency: STAGES cycles from input accept to out_valid, with no stalls. Default config: 4.
- Throughput: one transaction per cycle while out_ready=1.
- Stall: out_valid && !out_ready freezes all stages. sum/cout/overflow stay stable until accepted. in_ready=0 in the same cycle.
- Simultaneous out accept and in accept in the same cycle is legal; no bubble is inserted.
- Reset (rst=1 at an edge): all valid bits clear to 0; sum=0, cout=0, overflow=0; in_ready=1 in the cycle after reset. In-flight transactions are discarded, with no partial output.
- Reset has priority over advance.
- Wrap-around: sum is mod 2^WIDTH; excess reported only through cout/overflow.

## Structure
- Package pipelined_rca_pkg: helper function for STAGES; elaboration-time check that WIDTH % STAGE_W == 0 and STAGE_W ≥ 1.
- One sub-module, rca_slice: purely combinational STAGE_W-bit ripple of 1-bit full-adder cells. Ports: a, b, ci, s, co, plus c_msb (the carry into its top bit).
- Top instantiates STAGES rca_slice instances plus per-stage valid/carry/skew/de-skew registers.

## Test plan
- WIDTH=32, STAGE_W=8, sub=0: a=0xFFFFFFFF, b=0x00000001, cin=0. Expect sum=0x00000000, cout=1, overflow=0 after exactly 4 cycles. This proves carry across every slice.
- sub=1: a=0x80000000, b=0x00000001. Expect sum=0x7FFFFFFF, cout=1, overflow=1. Second case: a=5, b=7. Expect sum=0xFFFFFFFE, cout=0, overflow=0.
- Back-to-back stream of 8 transactions with out_ready=1 throughout. Expect 8 results on consecutive cycles, in order, starting 4 cycles after the first input.
- out_ready low for 3 cycles while the pipe is full. Expect in_ready=0 and outputs held stable; after release, no loss and no duplication; scoreboard matches a+b+cin.
- rst asserted for one cycle with 3 transactions in flight. Expect out_valid=0 on the next cycle, no stale results ever appear, and sum/cout/overflow=0.
- Random regression for STAGES=1 (STAGE_W=32) and STAGES=8 (STAGE_W=4), 10k ops each, with random in_valid and out_ready. Check sum/cout/overflow against a reference model of a+b+cin or a−b in (WIDTH+1)-bit arithmetic.

Source files
------------

// File: rtl/pipelined_rca_pkg.sv
// Shared elaboration helpers for the pipelined ripple-carry adder.
package pipelined_rca_pkg;

    function automatic int calc_stages(input int width, input int stage_w);
        return (stage_w < 1) ? 1 : width / stage_w;
    endfunction

    function automatic bit cfg_ok(input int width, input int stage_w);
        return (stage_w >= 1) && (width >= stage_w) && (width % stage_w == 0);
    endfunction

endpackage

// File: rtl/pipelined_rca_adder_rca_slice.sv
// Purely combinational W-bit ripple of full-adder cells; c_msb is the carry into the top bit.
module rca_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);
    logic [W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co    = c[W];
    assign c_msb = c[W-1];

endmodule

// File: rtl/pipelined_rca_adder.sv
// Add/subtract with the carry chain cut into STAGE_W-bit slices, one register stage per slice,
// and a single global advance so the whole pipe stalls together under back-pressure.
module pipelined_rca_adder
    import pipelined_rca_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STAGE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int STAGES = calc_stages(WIDTH, STAGE_W);
    localparam logic [WIDTH-1:0] SLICE_MASK = {WIDTH{1'b1}} >> (WIDTH - STAGE_W);

    if (!cfg_ok(WIDTH, STAGE_W)) begin : g_bad_cfg
        $error("pipelined_rca_adder: WIDTH must be a non-zero multiple of STAGE_W");
    end

    logic                          adv;
    logic [STAGES:1]               vld_q;
    logic [STAGES:0]               vld_pipe;
    logic [STAGES-1:0][WIDTH-1:0]  a_q, b_q, s_q;
    logic [STAGES-1:0][WIDTH-1:0]  a_src, b_src, s_src, s_d;
    logic [STAGES-1:0]             c_q, c_src, c_d, cmsb_w;
    logic                          cmsb_q;

    assign adv      = !vld_q[STAGES] || out_ready;
    assign in_ready = adv;
    assign vld_pipe = {vld_q, in_valid};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [STAGE_W-1:0] slice_s;

        // B is inverted on entry for subtract, so downstream stages never see the mode bit.
        if (k == 0) begin : g_head
            assign a_src[k] = a;
            assign b_src[k] = sub ? ~b : b;
            assign s_src[k] = '0;
            assign c_src[k] = sub | cin;
        end else begin : g_body
            assign a_src[k] = a_q[k-1];
            assign b_src[k] = b_q[k-1];
            assign s_src[k] = s_q[k-1];
            assign c_src[k] = c_q[k-1];
        end

        rca_slice #(.W(STAGE_W)) u_slice (
            .a     (a_src[k][k*STAGE_W +: STAGE_W]),
            .b     (b_src[k][k*STAGE_W +: STAGE_W]),
            .ci    (c_src[k]),
            .s     (slice_s),
            .co    (c_d[k]),
            .c_msb (cmsb_w[k])
        );

        assign s_d[k] = (s_src[k] & ~(SLICE_MASK << (k*STAGE_W)))
                      | (WIDTH'(slice_s) << (k*STAGE_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            c_q    <= '0;
            cmsb_q <= 1'b0;
        end else if (adv) begin
            vld_q  <= vld_pipe[STAGES-1:0];
            a_q    <= a_src;
            b_q    <= b_src;
            s_q    <= s_d;
            c_q    <= c_d;
            cmsb_q <= cmsb_w[STAGES-1];
        end
    end

    assign out_valid = vld_q[STAGES];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign overflow  = c_q[STAGES-1] ^ cmsb_q;

    // Operands are fully consumed by the last stage; lower-slice c_msb taps are not needed.
    logic unused_ok;
    assign unused_ok = ^{a_q[STAGES-1], b_q[STAGES-1], cmsb_w};

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Directed and randomized checks of the pipelined adder at STAGES = 4, 1 and 8.
module tb_pipelined_rca_adder;
    localparam int W  = 32;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [ND-1:0]        iv, ir, ov, ordy, cin, sub, co, ovf;
    logic [ND-1:0][W-1:0] a, b, s;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [W+1:0] sb [ND][$];

    always #5 clk = ~clk;

    for (genvar d = 0; d < ND; d++) begin : g_dut
        pipelined_rca_adder #(.WIDTH(W), .STAGE_W(d == 0 ? 8 : (d == 1 ? 32 : 4))) u_dut (
            .clk(clk), .rst(rst),
            .in_valid(iv[d]), .in_ready(ir[d]),
            .a(a[d]), .b(b[d]), .cin(cin[d]), .sub(sub[d]),
            .out_valid(ov[d]), .out_ready(ordy[d]),
            .sum(s[d]), .cout(co[d]), .overflow(ovf[d])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference: {cout, overflow, sum} from plain wide signed/unsigned arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic is_sub);
        longint ux, uy, ut, sx, sy, st;
        logic [W-1:0] res;
        logic signed [W-1:0] res_s;
        logic c_m, o_m;
        ux = x; uy = y;
        sx = $signed(x); sy = $signed(y);
        if (is_sub) begin
            ut = ux - uy; st = sx - sy; c_m = (ux >= uy);
        end else begin
            ut = ux + uy + longint'(ci); st = sx + sy + longint'(ci); c_m = ut[W];
        end
        res   = ut[W-1:0];
        res_s = res;
        o_m   = (st != longint'(res_s));
        return {c_m, o_m, res};
    endfunction

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] r;
        case ($urandom_range(0, 5))
            0:       r = 32'h0000_0000;
            1:       r = 32'hFFFF_FFFF;
            2:       r = 32'h8000_0000;
            3:       r = 32'h7FFF_FFFF;
            default: r = $urandom();
        endcase
        return r;
    endfunction

    task automatic drive_rand(input int d, input int pv);
        iv[d]  = ($urandom_range(0, 99) < pv);
        a[d]   = rnd_word();
        b[d]   = rnd_word();
        cin[d] = 1'($urandom_range(0, 1));
        sub[d] = 1'($urandom_range(0, 1));
    endtask

    // Sample handshakes mid-cycle, update scoreboards, then step past the next edge.
    task automatic tick();
        logic [W+1:0] e;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                sb[d].delete();
            end else begin
                if (ov[d] && ordy[d]) begin
                    if (sb[d].size() == 0) chk($sformatf("dut%0d_spurious_out", d), ov[d], 0);
                    else begin
                        e = sb[d].pop_front();
                        chk($sformatf("dut%0d_result", d), {co[d], ovf[d], s[d]}, e);
                    end
                end
                if (iv[d] && ir[d]) sb[d].push_back(model(a[d], b[d], cin[d], sub[d]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic dir_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic ci, input logic sb_m, input logic [W-1:0] es,
                          input logic ec, input logic eo);
        int lat;
        a[0] = av; b[0] = bv; cin[0] = ci; sub[0] = sb_m; iv[0] = 1'b1; ordy[0] = 1'b1;
        chk({tag, "_in_ready"}, ir[0], 1);
        @(posedge clk); #1;
        iv[0] = 1'b0;
        lat = 1;
        while (!ov[0] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 4);
        chk({tag, "_sum"}, s[0], es);
        chk({tag, "_cout"}, co[0], ec);
        chk({tag, "_ovf"}, ovf[0], eo);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [W+1:0] bq[$];
        logic [W+1:0] snap, e;
        int nout, waitc;
        bit busy;

        iv = '0; ordy = '1; a = '0; b = '0; cin = '0; sub = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int d = 0; d < ND; d++) begin
            chk($sformatf("rst_out_valid%0d", d), ov[d], 0);
            chk($sformatf("rst_in_ready%0d", d), ir[d], 1);
        end
        chk("rst_sum", s[0], 0);
        chk("rst_cout_ovf", {co[0], ovf[0]}, 0);

        dir_op("carry_all", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        dir_op("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        dir_op("sub_neg",   32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);

        // Back-to-back stream: results expected on consecutive cycles starting 4 after the first.
        nout = 0;
        for (int c = 0; c < 20; c++) begin
            if (c < 8) begin
                iv[0] = 1'b1; a[0] = $urandom(); b[0] = $urandom();
                cin[0] = 1'($urandom_range(0, 1)); sub[0] = 1'($urandom_range(0, 1));
                bq.push_back(model(a[0], b[0], cin[0], sub[0]));
            end else iv[0] = 1'b0;
            @(negedge clk);
            if (ov[0]) begin
                chk("b2b_cycle", c, 4 + nout);
                if (bq.size() == 0) chk("b2b_extra_out", ov[0], 0);
                else begin
                    e = bq.pop_front();
                    chk("b2b_data", {co[0], ovf[0], s[0]}, e);
                end
                nout++;
            end
            @(posedge clk); #1;
        end
        chk("b2b_count", nout, 8);

        // Fill the pipe with the consumer stalled, hold 3 cycles, then drain.
        ordy[0] = 1'b0;
        waitc = 0;
        drive_rand(0, 100);
        tick();
        while (!ov[0] && waitc < 20) begin
            drive_rand(0, 100);
            tick();
            waitc++;
        end
        chk("stall_filled", ov[0], 1);
        snap = {co[0], ovf[0], s[0]};
        for (int i = 0; i < 3; i++) begin
            drive_rand(0, 100);
            chk("stall_in_ready", ir[0], 0);
            chk("stall_hold", {co[0], ovf[0], s[0]}, snap);
            tick();
        end
        chk("stall_hold_end", {co[0], ovf[0], s[0]}, snap);
        chk("stall_queue_depth", sb[0].size(), 4);
        ordy[0] = 1'b1; iv[0] = 1'b0;
        waitc = 0;
        while ((sb[0].size() > 0 || ov[0]) && waitc < 30) begin
            tick();
            waitc++;
        end
        repeat (3) tick();
        chk("stall_drained", sb[0].size(), 0);

        // Reset with three transactions in flight.
        for (int i = 0; i < 3; i++) begin
            drive_rand(0, 100);
            tick();
        end
        iv[0] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", ov[0], 0);
        chk("midrst_sum", s[0], 0);
        chk("midrst_cout_ovf", {co[0], ovf[0]}, 0);
        chk("midrst_in_ready", ir[0], 1);
        repeat (8) tick();
        chk("midrst_no_stale", ov[0], 0);

        // Random regression on all three depths with random valid and back-pressure.
        for (int c = 0; c < 10000; c++) begin
            for (int d = 0; d < ND; d++) begin
                drive_rand(d, 70);
                ordy[d] = ($urandom_range(0, 99) < 70);
            end
            tick();
        end
        iv = '0; ordy = '1;
        waitc = 0;
        busy = 1'b1;
        while (busy && waitc < 50) begin
            tick();
            waitc++;
            busy = 1'b0;
            for (int d = 0; d < ND; d++) if (sb[d].size() > 0 || ov[d]) busy = 1'b1;
        end
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("rand_drain%0d", d), sb[d].size(), 0);
            chk($sformatf("rand_idle%0d", d), ov[d], 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
